// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only master port used to fetch the two sysid words.
interface sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them against
// the expected build values, with a per-read timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5723_15FD,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  sysid_checker_if.master        avm,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   id_ok_o,
  output logic                   ts_ok_o,
  output logic                   timeout_o,
  output logic [31:0]            id_value_o,
  output logic [31:0]            ts_value_o
);

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StDone
  } state_e;

  localparam logic [15:0] LastCount = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic last_cnt;
  logic in_flight_q;
  logic in_wait_q;
  logic start_accept;
  logic timeout_hit;

  assign last_cnt     = (cnt_q == LastCount);
  assign in_flight_q  = (state_q == StIdReq) || (state_q == StIdWait) ||
                        (state_q == StTsReq) || (state_q == StTsWait);
  assign in_wait_q    = (state_q == StIdWait) || (state_q == StTsWait);
  assign start_accept = ((state_q == StIdle) || (state_q == StDone)) && start_i;
  // Data arriving on the final counted cycle beats the timeout.
  assign timeout_hit  = in_flight_q && last_cnt && !(in_wait_q && avm.avm_readdatavalid);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) state_d = StIdReq;
      end
      StIdReq: begin
        if (last_cnt)                    state_d = StDone;
        else if (!avm.avm_waitrequest)   state_d = StIdWait;
      end
      StIdWait: begin
        if (avm.avm_readdatavalid)       state_d = StTsReq;
        else if (last_cnt)               state_d = StDone;
      end
      StTsReq: begin
        if (last_cnt)                    state_d = StDone;
        else if (!avm.avm_waitrequest)   state_d = StTsWait;
      end
      StTsWait: begin
        if (avm.avm_readdatavalid || last_cnt) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    if (in_flight_q) cnt_d = cnt_q + 16'd1;
    if (((state_d == StIdReq) || (state_d == StTsReq)) && (state_d != state_q)) cnt_d = '0;

    if (start_accept) begin
      pass_d     = 1'b0;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      timeout_d  = 1'b0;
      id_value_d = '0;
      ts_value_d = '0;
    end

    if ((state_q == StIdWait) && avm.avm_readdatavalid) begin
      id_value_d = avm.avm_readdata;
      id_ok_d    = (avm.avm_readdata == EXPECTED_ID);
    end

    if ((state_q == StTsWait) && avm.avm_readdatavalid) begin
      ts_value_d = avm.avm_readdata;
      ts_ok_d    = (avm.avm_readdata == EXPECTED_TIMESTAMP);
      pass_d     = id_ok_q && (avm.avm_readdata == EXPECTED_TIMESTAMP);
    end

    if (timeout_hit) begin
      timeout_d = 1'b1;
      pass_d    = 1'b0;
    end

    read_d = (state_d == StIdReq) || (state_d == StTsReq);
    addr_d = (state_d == StTsReq) || (state_d == StTsWait);
    busy_d = (state_d == StIdReq) || (state_d == StIdWait) ||
             (state_d == StTsReq) || (state_d == StTsWait);
    done_d = (state_d == StDone);
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign id_ok_o         = id_ok_q;
  assign ts_ok_o         = ts_ok_q;
  assign timeout_o       = timeout_q;
  assign id_value_o      = id_value_q;
  assign ts_value_o      = ts_value_q;

endmodule
